// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: program control (start/stall/branch/target), the
// instruction-memory read port, the decode-side instruction/opcode and status.
//   master : the fetch sequencer (drives imem_addr, instr, opcode, status)
//   slave  : the surrounding system (drives control inputs and imem_data)
interface instr_fetch_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned CNT_W   = 16
) ();

  localparam int unsigned OP_W = 6;

  logic               start;
  logic               stall;
  logic               branch;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [OP_W-1:0]    opcode;
  logic               valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    input  start, stall, branch, target, imem_data,
    output imem_addr, instr, opcode, valid, busy, done, cycle_count
  );

  modport slave (
    output start, stall, branch, target, imem_data,
    input  imem_addr, instr, opcode, valid, busy, done, cycle_count
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: holds the PC, drives the instruction-memory
// address, passes the fetched instruction/opcode to decode and runs an
// IDLE -> RUN -> DONE program sequence with a saturating RUN-cycle counter.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high reset (wins over start)
//   bus   : instr_fetch_if.master (control in, imem port, decode out, status)
module instr_fetch #(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [5:0]      HALT_OP    = 6'b111111,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int unsigned      OP_W    = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, done_q;
  logic [OP_W-1:0]  opcode_c;

  // Zero-cycle fetch: instruction and opcode come straight from the async ROM.
  assign opcode_c        = bus.imem_data[INSTR_W-1 -: OP_W];
  assign bus.instr       = bus.imem_data;
  assign bus.opcode      = opcode_c;
  assign bus.imem_addr   = pc_q;
  assign bus.cycle_count = cnt_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = valid_q;
  assign bus.done        = done_q;

  // Next-state, next-PC and next-count selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN edge counts, including stall and halt edges.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (!bus.stall) begin
          if (opcode_c == HALT_OP) begin
            state_d = DONE;           // PC stays on the halt instruction
          end else if (bus.branch) begin
            pc_d = bus.target;
          end else begin
            pc_d = pc_q + PC_W'(1);   // wraps silently at 2^PC_W
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

endmodule
